// File: rtl/bus_datapath_pkg.sv
// ----------------------------------------------------------------------------
// bus_datapath_pkg
// Shared constants for the single-bus datapath.
//   - WIDTH / NREGS     : data width and general register count
//   - OP_*              : ALU operation codes carried on op_sel
//   - SRC_*             : bus-source indices; a lower index wins the bus
//   - sext_c()          : builds the constant-path value from IR
// Optional feature macro: ALU_DIV_EN (used by datapath_alu).
// ----------------------------------------------------------------------------
package bus_datapath_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Indices 0..NREGS-1 are the general registers.
  localparam int SRC_HI  = NREGS + 0;
  localparam int SRC_LO  = NREGS + 1;
  localparam int SRC_ZHI = NREGS + 2;
  localparam int SRC_ZLO = NREGS + 3;
  localparam int SRC_PC  = NREGS + 4;
  localparam int SRC_MDR = NREGS + 5;
  localparam int SRC_MAR = NREGS + 6;
  localparam int SRC_IN  = NREGS + 7;
  localparam int SRC_C   = NREGS + 8;
  localparam int NSRC    = NREGS + 9;

  // Constant path: IR[18:0] sign-extended to the full word.
  function automatic logic [WIDTH-1:0] sext_c(input logic [WIDTH-1:0] ir);
    return {{(WIDTH-19){ir[18]}}, ir[18:0]};
  endfunction

endpackage

// File: rtl/bus_datapath_if.sv
// ----------------------------------------------------------------------------
// bus_datapath_if
// Control strobes, data inputs and debug views of the datapath.
//   master : control unit side (drives strobes/data, reads views)
//   slave  : datapath side (reads strobes/data, drives views and BusMuxOut)
// ----------------------------------------------------------------------------
interface bus_datapath_if;
  import bus_datapath_pkg::*;

  logic [NREGS-1:0] R_rd;
  logic [NREGS-1:0] R_wrt;
  logic HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
  logic HI_rd, LO_rd, MAR_rd, Zhi_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd;
  logic IncPC;
  logic Read;
  logic [4:0] op_sel;
  logic [WIDTH-1:0] Mdatain;
  logic [WIDTH-1:0] InPort_data;

  logic [WIDTH-1:0] r2_view, r6_view, Y_view, Zhi_view, Zlo_view;
  logic [WIDTH-1:0] HI_view, LO_view, MDR_view, PC_view;
  logic [WIDTH-1:0] BusMuxOut;
  logic [WIDTH-1:0] Data_view;

  modport master (
    output R_rd, R_wrt,
    output HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out,
    output HI_rd, LO_rd, MAR_rd, Zhi_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd,
    output IncPC, Read, op_sel, Mdatain, InPort_data,
    input  r2_view, r6_view, Y_view, Zhi_view, Zlo_view,
    input  HI_view, LO_view, MDR_view, PC_view, BusMuxOut, Data_view
  );

  modport slave (
    input  R_rd, R_wrt,
    input  HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out,
    input  HI_rd, LO_rd, MAR_rd, Zhi_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd,
    input  IncPC, Read, op_sel, Mdatain, InPort_data,
    output r2_view, r6_view, Y_view, Zhi_view, Zlo_view,
    output HI_view, LO_view, MDR_view, PC_view, BusMuxOut, Data_view
  );
endinterface

// File: rtl/bus_datapath_alu.sv
// ----------------------------------------------------------------------------
// datapath_alu
// Combinational ALU: A (Y register) and B (bus) -> 64-bit {hi, lo} result.
//   a_i, b_i  : operands
//   op_sel_i  : operation code (OP_* in bus_datapath_pkg)
//   result_o  : {hi, lo}; hi is zero except for mul and div
// Optional feature macro: ALU_DIV_EN enables signed division on OP_DIV;
// without it OP_DIV returns 0 and no divider is built.
// ----------------------------------------------------------------------------
module datapath_alu
  import bus_datapath_pkg::*;
(
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [4:0]         op_sel_i,
  output logic [2*WIDTH-1:0] result_o
);

  logic [4:0]         sh;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] ror_w, rol_w;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  assign sh    = b_i[4:0];
  // Rotating a doubled word by sh and picking one half gives the rotate.
  assign dbl   = {a_i, a_i};
  assign ror_w = dbl >> sh;
  assign rol_w = dbl << sh;
  assign a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_ext = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod  = a_ext * b_ext;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] quot, rem;
  always_comb begin
    quot = '1;
    rem  = a_i;
    if (b_i != '0) begin
      quot = $unsigned($signed(a_i) / $signed(b_i));
      rem  = $unsigned($signed(a_i) % $signed(b_i));
    end
  end
`endif

  always_comb begin
    result_o = '0;
    case (op_sel_i)
      OP_ADD:  result_o[WIDTH-1:0] = a_i + b_i;
      OP_SUB:  result_o[WIDTH-1:0] = a_i - b_i;
      OP_AND:  result_o[WIDTH-1:0] = a_i & b_i;
      OP_OR:   result_o[WIDTH-1:0] = a_i | b_i;
      OP_ROR:  result_o[WIDTH-1:0] = ror_w[WIDTH-1:0];
      OP_ROL:  result_o[WIDTH-1:0] = rol_w[2*WIDTH-1:WIDTH];
      OP_SHR:  result_o[WIDTH-1:0] = a_i >> sh;
      OP_SHRA: result_o[WIDTH-1:0] = $unsigned($signed(a_i) >>> sh);
      OP_SHL:  result_o[WIDTH-1:0] = a_i << sh;
      OP_MUL:  result_o            = prod;
`ifdef ALU_DIV_EN
      OP_DIV:  result_o            = {rem, quot};
`endif
      OP_NEG:  result_o[WIDTH-1:0] = '0 - b_i;
      OP_NOT:  result_o[WIDTH-1:0] = ~b_i;
      default: result_o            = '0;
    endcase
  end

endmodule

// File: rtl/bus_datapath.sv
// ----------------------------------------------------------------------------
// bus_datapath
// Single-bus 32-bit CPU datapath: R0..R15, HI, LO, PC, IR, MAR, MDR, Y,
// Zhi/Zlo, InPort, constant path and ALU, all sharing BusMuxOut.
//   clk : rising-edge clock
//   clr : asynchronous active-low clear of every register
//   bus : bus_datapath_if.slave - control strobes, memory/input data,
//         register views, BusMuxOut and Data_view (MDR D-input)
// Optional feature macro: ALU_DIV_EN (see datapath_alu).
// ----------------------------------------------------------------------------
module bus_datapath
  import bus_datapath_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  bus_datapath_if.slave  bus
);

  logic [WIDTH-1:0] r_q [NREGS];
  logic [WIDTH-1:0] hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q, in_q;
  logic [WIDTH-1:0] bus_d, mdr_d;
  logic [2*WIDTH-1:0] alu_res;

  logic [NSRC-1:0]  src_sel;
  logic [WIDTH-1:0] src_val [NSRC];

  // ---- bus encoder ---------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_src_reg
      assign src_sel[gi] = bus.R_wrt[gi];
      assign src_val[gi] = r_q[gi];
    end
  endgenerate

  assign src_sel[SRC_HI]  = bus.HI_out;   assign src_val[SRC_HI]  = hi_q;
  assign src_sel[SRC_LO]  = bus.LO_out;   assign src_val[SRC_LO]  = lo_q;
  assign src_sel[SRC_ZHI] = bus.Zhi_out;  assign src_val[SRC_ZHI] = zhi_q;
  assign src_sel[SRC_ZLO] = bus.Zlo_out;  assign src_val[SRC_ZLO] = zlo_q;
  assign src_sel[SRC_PC]  = bus.PC_out;   assign src_val[SRC_PC]  = pc_q;
  assign src_sel[SRC_MDR] = bus.MDR_out;  assign src_val[SRC_MDR] = mdr_q;
  assign src_sel[SRC_MAR] = bus.MAR_out;  assign src_val[SRC_MAR] = mar_q;
  assign src_sel[SRC_IN]  = bus.In_out;   assign src_val[SRC_IN]  = in_q;
  assign src_sel[SRC_C]   = bus.C_out;    assign src_val[SRC_C]   = sext_c(ir_q);

  // Scanning from the highest index down lets the lowest asserted index win.
  always_comb begin
    bus_d = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_sel[i]) bus_d = src_val[i];
    end
  end

  assign mdr_d = bus.Read ? bus.Mdatain : bus_d;

  datapath_alu u_alu (
    .a_i      (y_q),
    .b_i      (bus_d),
    .op_sel_i (bus.op_sel),
    .result_o (alu_res)
  );

  // ---- registers -----------------------------------------------------------
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge clr) begin
        if (!clr)                r_q[gi] <= '0;
        else if (bus.R_rd[gi])   r_q[gi] <= bus_d;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hi_q  <= '0; lo_q  <= '0; pc_q  <= '0; ir_q  <= '0; mar_q <= '0;
      mdr_q <= '0; y_q   <= '0; zhi_q <= '0; zlo_q <= '0; in_q  <= '0;
    end else begin
      in_q <= bus.InPort_data;
      if (bus.HI_rd)  hi_q  <= bus_d;
      if (bus.LO_rd)  lo_q  <= bus_d;
      if (bus.IR_rd)  ir_q  <= bus_d;
      if (bus.MAR_rd) mar_q <= bus_d;
      if (bus.Y_rd)   y_q   <= bus_d;
      if (bus.MDR_rd) mdr_q <= mdr_d;
      if (bus.Zhi_rd) zhi_q <= alu_res[2*WIDTH-1:WIDTH];
      if (bus.Zlo_rd) zlo_q <= alu_res[WIDTH-1:0];
      // A bus load overrides the increment strobe.
      if (bus.PC_rd)      pc_q <= bus_d;
      else if (bus.IncPC) pc_q <= pc_q + 1'b1;
    end
  end

  // ---- views ---------------------------------------------------------------
  assign bus.r2_view   = r_q[2];
  assign bus.r6_view   = r_q[6];
  assign bus.Y_view    = y_q;
  assign bus.Zhi_view  = zhi_q;
  assign bus.Zlo_view  = zlo_q;
  assign bus.HI_view   = hi_q;
  assign bus.LO_view   = lo_q;
  assign bus.MDR_view  = mdr_q;
  assign bus.PC_view   = pc_q;
  assign bus.BusMuxOut = bus_d;
  assign bus.Data_view = mdr_d;

endmodule

// File: tb/tb_bus_datapath.sv
module tb_bus_datapath;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  bus_datapath_if dif ();

  bus_datapath dut (
    .clk (clk),
    .clr (clr),
    .bus (dif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---- stimulus helpers ----------------------------------------------------
  task automatic idle();
    dif.R_rd = '0; dif.R_wrt = '0;
    dif.HI_out = 0; dif.LO_out = 0; dif.Zhi_out = 0; dif.Zlo_out = 0; dif.PC_out = 0;
    dif.MDR_out = 0; dif.MAR_out = 0; dif.In_out = 0; dif.C_out = 0;
    dif.HI_rd = 0; dif.LO_rd = 0; dif.MAR_rd = 0; dif.Zhi_rd = 0; dif.Zlo_rd = 0;
    dif.PC_rd = 0; dif.MDR_rd = 0; dif.IR_rd = 0; dif.Y_rd = 0;
    dif.IncPC = 0; dif.Read = 0; dif.op_sel = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mem_to_mdr(input logic [31:0] v);
    idle(); dif.Read = 1; dif.Mdatain = v; dif.MDR_rd = 1; cyc(); idle();
  endtask

  task automatic mdr_to_reg(input int i);
    idle(); dif.MDR_out = 1; dif.R_rd[i] = 1; cyc(); idle();
  endtask

  task automatic mdr_to_y();
    idle(); dif.MDR_out = 1; dif.Y_rd = 1; cyc(); idle();
  endtask

  task automatic alu_mdr(input logic [4:0] op);
    idle(); dif.MDR_out = 1; dif.op_sel = op; dif.Zhi_rd = 1; dif.Zlo_rd = 1; cyc(); idle();
  endtask

  // ---- tests ---------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] v [10];
    clr = 0;
    dif.R_rd = '1; dif.R_wrt = '1;
    dif.HI_out = 1; dif.LO_out = 1; dif.Zhi_out = 1; dif.Zlo_out = 1; dif.PC_out = 1;
    dif.MDR_out = 1; dif.MAR_out = 1; dif.In_out = 1; dif.C_out = 1;
    dif.HI_rd = 1; dif.LO_rd = 1; dif.MAR_rd = 1; dif.Zhi_rd = 1; dif.Zlo_rd = 1;
    dif.PC_rd = 1; dif.MDR_rd = 1; dif.IR_rd = 1; dif.Y_rd = 1;
    dif.IncPC = 1; dif.Read = 1; dif.op_sel = 5'b10010;
    dif.Mdatain = 32'hFFFFFFFF; dif.InPort_data = 32'hFFFFFFFF;
    repeat (3) cyc();
    for (int k = 0; k < 10; k++) exp_q.push_back(32'h0);
    v = '{dif.r2_view, dif.r6_view, dif.Y_view, dif.Zhi_view, dif.Zlo_view,
          dif.HI_view, dif.LO_view, dif.MDR_view, dif.PC_view, dif.BusMuxOut};
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front(); n_checks++;
      if (v[k] !== e) begin
        n_fail++; $display("FAIL reset_view%0d: got %h expected %h", k, v[k], e);
      end
    end
    idle();
    clr = 1; #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    cyc();
    e = exp_q.pop_front(); n_checks++;
    if (dif.PC_view !== e) begin n_fail++; $display("FAIL release_pc: got %h expected %h", dif.PC_view, e); end
    e = exp_q.pop_front(); n_checks++;
    if (dif.MDR_view !== e) begin n_fail++; $display("FAIL release_mdr: got %h expected %h", dif.MDR_view, e); end
    $display("test_reset done");
  endtask

  task automatic test_reg_load();
    exp_q.push_back(32'h00FF5000);
    mem_to_mdr(32'h00FF5000);
    e = exp_q.pop_front(); n_checks++;
    if (dif.MDR_view !== e) begin n_fail++; $display("FAIL mdr_load: got %h expected %h", dif.MDR_view, e); end
    exp_q.push_back(32'h00FF5000);
    mdr_to_reg(2);
    e = exp_q.pop_front(); n_checks++;
    if (dif.r2_view !== e) begin n_fail++; $display("FAIL r2_load: got %h expected %h", dif.r2_view, e); end
    exp_q.push_back(32'hFFFF0054);
    mem_to_mdr(32'hFFFF0054);
    mdr_to_reg(6);
    e = exp_q.pop_front(); n_checks++;
    if (dif.r6_view !== e) begin n_fail++; $display("FAIL r6_load: got %h expected %h", dif.r6_view, e); end
    $display("test_reg_load done r2=%h r6=%h", dif.r2_view, dif.r6_view);
  endtask

  task automatic test_mul();
    idle(); dif.R_wrt[2] = 1; dif.Y_rd = 1; cyc(); idle();
    exp_q.push_back(32'hFFFFFF01); exp_q.push_back(32'h03C64000);
    dif.R_wrt[6] = 1; dif.op_sel = 5'b10000; dif.Zhi_rd = 1; dif.Zlo_rd = 1; cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.Zhi_view !== e) begin n_fail++; $display("FAIL mul_hi: got %h expected %h", dif.Zhi_view, e); end
    e = exp_q.pop_front(); n_checks++;
    if (dif.Zlo_view !== e) begin n_fail++; $display("FAIL mul_lo: got %h expected %h", dif.Zlo_view, e); end
    exp_q.push_back(32'h03C64000);
    dif.Zlo_out = 1; dif.LO_rd = 1; cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.LO_view !== e) begin n_fail++; $display("FAIL lo_load: got %h expected %h", dif.LO_view, e); end
    exp_q.push_back(32'hFFFFFF01);
    dif.Zhi_out = 1; dif.HI_rd = 1; cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.HI_view !== e) begin n_fail++; $display("FAIL hi_load: got %h expected %h", dif.HI_view, e); end
    $display("test_mul done hi=%h lo=%h", dif.HI_view, dif.LO_view);
  endtask

  task automatic test_pc();
    mem_to_mdr(32'd7);
    exp_q.push_back(32'd7);
    dif.MDR_out = 1; dif.PC_rd = 1; cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.PC_view !== e) begin n_fail++; $display("FAIL pc_load: got %h expected %h", dif.PC_view, e); end
    exp_q.push_back(32'd8);
    dif.IncPC = 1; cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.PC_view !== e) begin n_fail++; $display("FAIL pc_inc: got %h expected %h", dif.PC_view, e); end
    mem_to_mdr(32'h00000100);
    exp_q.push_back(32'h00000100);
    dif.MDR_out = 1; dif.PC_rd = 1; dif.IncPC = 1; cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.PC_view !== e) begin n_fail++; $display("FAIL pc_prio: got %h expected %h", dif.PC_view, e); end
    mem_to_mdr(32'hFFFFFFFF);
    dif.MDR_out = 1; dif.PC_rd = 1; cyc(); idle();
    exp_q.push_back(32'h0);
    dif.IncPC = 1; cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.PC_view !== e) begin n_fail++; $display("FAIL pc_wrap: got %h expected %h", dif.PC_view, e); end
    $display("test_pc done pc=%h", dif.PC_view);
  endtask

  task automatic test_alu_sweep();
    logic [4:0]  ops [13];
    logic [31:0] elo [13];
    logic [31:0] ehi [13];
    ops = '{5'b00111, 5'b01010, 5'b01001, 5'b00100, 5'b00011, 5'b00101, 5'b00110,
            5'b01000, 5'b01011, 5'b10001, 5'b10010, 5'b10000, 5'b11111};
    elo = '{32'h18000000, 32'hF8000000, 32'h08000000, 32'h7FFFFFFD, 32'h80000005,
            32'h00000000, 32'h80000005, 32'h00000018, 32'h00000010, 32'hFFFFFFFC,
            32'hFFFFFFFB, 32'h00000004, 32'h00000000};
    ehi = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h0, 32'hFFFFFFFE, 32'h0};
    mem_to_mdr(32'h80000001); mdr_to_y();
    mem_to_mdr(32'd4);
    for (int k = 0; k < 13; k++) begin
      exp_q.push_back(elo[k]); exp_q.push_back(ehi[k]);
      alu_mdr(ops[k]);
      e = exp_q.pop_front(); n_checks++;
      if (dif.Zlo_view !== e) begin n_fail++; $display("FAIL alu_lo op=%b: got %h expected %h", ops[k], dif.Zlo_view, e); end
      e = exp_q.pop_front(); n_checks++;
      if (dif.Zhi_view !== e) begin n_fail++; $display("FAIL alu_hi op=%b: got %h expected %h", ops[k], dif.Zhi_view, e); end
      $display("alu op=%b hi=%h lo=%h", ops[k], dif.Zhi_view, dif.Zlo_view);
    end
    // Zlo alone must leave Zhi alone (Zhi holds 0 from the invalid op).
    exp_q.push_back(32'hFFFFFFFB); exp_q.push_back(32'h0);
    idle(); dif.MDR_out = 1; dif.op_sel = 5'b10010; dif.Zlo_rd = 1; cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.Zlo_view !== e) begin n_fail++; $display("FAIL zlo_only_lo: got %h expected %h", dif.Zlo_view, e); end
    e = exp_q.pop_front(); n_checks++;
    if (dif.Zhi_view !== e) begin n_fail++; $display("FAIL zlo_only_hi: got %h expected %h", dif.Zhi_view, e); end
    // Division: -4 / 3, then -4 / 0.
    mem_to_mdr(32'hFFFFFFFC); mdr_to_y();
    mem_to_mdr(32'd3);
`ifdef ALU_DIV_EN
    exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(32'hFFFFFFFF);
`else
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
`endif
    alu_mdr(5'b01111);
    e = exp_q.pop_front(); n_checks++;
    if (dif.Zlo_view !== e) begin n_fail++; $display("FAIL div_lo: got %h expected %h", dif.Zlo_view, e); end
    e = exp_q.pop_front(); n_checks++;
    if (dif.Zhi_view !== e) begin n_fail++; $display("FAIL div_hi: got %h expected %h", dif.Zhi_view, e); end
    mem_to_mdr(32'd0);
`ifdef ALU_DIV_EN
    exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(32'hFFFFFFFC);
`else
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
`endif
    alu_mdr(5'b01111);
    e = exp_q.pop_front(); n_checks++;
    if (dif.Zlo_view !== e) begin n_fail++; $display("FAIL div0_lo: got %h expected %h", dif.Zlo_view, e); end
    e = exp_q.pop_front(); n_checks++;
    if (dif.Zhi_view !== e) begin n_fail++; $display("FAIL div0_hi: got %h expected %h", dif.Zhi_view, e); end
    $display("test_alu_sweep done");
  endtask

  task automatic test_bus();
    idle(); #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if (dif.BusMuxOut !== e) begin n_fail++; $display("FAIL bus_idle: got %h expected %h", dif.BusMuxOut, e); end
    mem_to_mdr(32'h33333333); mdr_to_reg(3);
    mem_to_mdr(32'h44444444);
    dif.MDR_out = 1; dif.HI_rd = 1; cyc(); idle();
    exp_q.push_back(32'h44444444);
    dif.HI_out = 1; #1;
    e = exp_q.pop_front(); n_checks++;
    if (dif.BusMuxOut !== e) begin n_fail++; $display("FAIL bus_hi: got %h expected %h", dif.BusMuxOut, e); end
    exp_q.push_back(32'h33333333);
    dif.R_wrt[3] = 1; #1;
    e = exp_q.pop_front(); n_checks++;
    if (dif.BusMuxOut !== e) begin n_fail++; $display("FAIL bus_prio: got %h expected %h", dif.BusMuxOut, e); end
    idle();
    mem_to_mdr(32'h0007FFFF);
    dif.MDR_out = 1; dif.IR_rd = 1; cyc(); idle();
    exp_q.push_back(32'hFFFFFFFF);
    dif.C_out = 1; #1;
    e = exp_q.pop_front(); n_checks++;
    if (dif.BusMuxOut !== e) begin n_fail++; $display("FAIL bus_c_neg: got %h expected %h", dif.BusMuxOut, e); end
    idle();
    mem_to_mdr(32'hFFF3FFFF);
    dif.MDR_out = 1; dif.IR_rd = 1; cyc(); idle();
    exp_q.push_back(32'h0003FFFF);
    dif.C_out = 1; #1;
    e = exp_q.pop_front(); n_checks++;
    if (dif.BusMuxOut !== e) begin n_fail++; $display("FAIL bus_c_pos: got %h expected %h", dif.BusMuxOut, e); end
    idle();
    dif.InPort_data = 32'hCAFEBABE; cyc();
    exp_q.push_back(32'hCAFEBABE);
    dif.In_out = 1; #1;
    e = exp_q.pop_front(); n_checks++;
    if (dif.BusMuxOut !== e) begin n_fail++; $display("FAIL bus_in: got %h expected %h", dif.BusMuxOut, e); end
    idle();
    exp_q.push_back(32'h12345678);
    dif.Read = 1; dif.Mdatain = 32'h12345678; #1;
    e = exp_q.pop_front(); n_checks++;
    if (dif.Data_view !== e) begin n_fail++; $display("FAIL data_mem: got %h expected %h", dif.Data_view, e); end
    exp_q.push_back(32'h33333333);
    dif.Read = 0; dif.R_wrt[3] = 1; #1;
    e = exp_q.pop_front(); n_checks++;
    if (dif.Data_view !== e) begin n_fail++; $display("FAIL data_bus: got %h expected %h", dif.Data_view, e); end
    idle();
    $display("test_bus done");
  endtask

  task automatic test_back_to_back();
    mem_to_mdr(32'hAAAA5555); mdr_to_reg(2);
    mem_to_mdr(32'h5A5A0F0F); mdr_to_reg(6);
    // R6 drives while R2 and R6 both load: R2 takes old R6, R6 keeps itself.
    exp_q.push_back(32'h5A5A0F0F); exp_q.push_back(32'h5A5A0F0F);
    dif.R_wrt[6] = 1; dif.R_rd[2] = 1; dif.R_rd[6] = 1; cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.r2_view !== e) begin n_fail++; $display("FAIL b2b_r2: got %h expected %h", dif.r2_view, e); end
    e = exp_q.pop_front(); n_checks++;
    if (dif.r6_view !== e) begin n_fail++; $display("FAIL b2b_r6: got %h expected %h", dif.r6_view, e); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_midop();
    mem_to_mdr(32'h0BADF00D);
    dif.MDR_out = 1; dif.PC_rd = 1; cyc(); idle();
    clr = 0; #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if (dif.MDR_view !== e) begin n_fail++; $display("FAIL midrst_mdr: got %h expected %h", dif.MDR_view, e); end
    e = exp_q.pop_front(); n_checks++;
    if (dif.PC_view !== e) begin n_fail++; $display("FAIL midrst_pc: got %h expected %h", dif.PC_view, e); end
    #2;
    dif.Read = 1; dif.Mdatain = 32'h600DCAFE; dif.MDR_rd = 1;
    clr = 1; #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_checks++;
    if (dif.MDR_view !== e) begin n_fail++; $display("FAIL release_hold: got %h expected %h", dif.MDR_view, e); end
    exp_q.push_back(32'h600DCAFE);
    cyc(); idle();
    e = exp_q.pop_front(); n_checks++;
    if (dif.MDR_view !== e) begin n_fail++; $display("FAIL release_load: got %h expected %h", dif.MDR_view, e); end
    $display("test_reset_midop done");
  endtask

  initial begin
    idle();
    dif.Mdatain = '0; dif.InPort_data = '0;
    test_reset();
    test_reg_load();
    test_mul();
    test_pc();
    test_alu_sweep();
    test_bus();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_datapath.md
Name: bus_datapath

Overview:
- Single-bus 32-bit CPU datapath: 16 general registers, HI/LO, PC, IR, MAR, MDR, Y, 64-bit Z (hi/lo halves), input port, constant path and an ALU.
- All sources drive one shared 32-bit bus (BusMuxOut) through a select encoder. All sinks load from the bus on the rising clock edge when enabled.
- Sits under the control unit. Every control strobe is an input port; internal values are exported as view ports for debug and verification.

Parameters:
- WIDTH, 32, data and bus width (the design is fixed at 32; Z is 2*WIDTH).
- NREGS, 16, number of general registers.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low; clears every register to 0.
- R_rd  in  16  per-register load-from-bus enable (bit i loads Ri).
- R_wrt  in  16  per-register drive-bus select (bit i puts Ri on the bus).
- HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out  in  1 each  bus drive selects.
- HI_rd, LO_rd, MAR_rd, Zhi_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd  in  1 each  load enables.
- IncPC  in  1  PC increment strobe.
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
- op_sel  in  5  ALU operation.
- Mdatain  in  32  memory read data.
- InPort_data  in  32  external input-port data.
- r2_view, r6_view, Y_view, Zhi_view, Zlo_view, HI_view, LO_view, MDR_view, PC_view  out  32  register contents.
- BusMuxOut  out  32  current bus value.
- Data_view  out  32  MDR D-input (post Read mux).

Behaviour:
- Reset: while clr = 0, R0..R15, HI, LO, PC, IR, MAR, MDR, Y, Zhi, Zlo and InPort are 0, asynchronously. All view outputs therefore read 0.
- Bus encoder (combinational):
  - Priority order: R0..R15, HI, LO, Zhi, Zlo, PC, MDR, MAR, In, C.
  - If no select is asserted, the bus is 0.
  - Controllers assert one-hot; the priority only resolves overlap deterministically.
- C source: IR[18:0] sign-extended to 32 bits.
- In source: InPort register, which loads InPort_data every clock.
- Register loads occur on posedge clk when the enable is high, and take the bus value present at that edge. Single-cycle latency.
- MDR: on MDR_rd, loads Read ? Mdatain : BusMuxOut. Data_view shows this mux output continuously.
- PC: PC_rd loads the bus. Otherwise, when IncPC is high, PC <= PC + 1 (wraps at 2^32). PC_rd has priority over IncPC.
- ALU (combinational): A = Y, B = BusMuxOut, 64-bit result {hi, lo}. On an edge, Zhi_rd loads hi and Zlo_rd loads lo, independently.
- op_sel encoding (lo = low result word; hi = 0 unless stated):
  - 00011 add: lo = A+B, mod 2^32.
  - 00100 sub: lo = A-B.
  - 00101 and; 00110 or.
  - 00111 ror; 01000 rol. Shift amount is B[4:0].
  - 01001 shr, logical; 01010 shra, arithmetic; 01011 shl. Shift amount is B[4:0].
  - 10000 mul: signed A*B, full 64-bit product in hi:lo.
  - 01111 div: signed; lo = quotient, hi = remainder, remainder takes the dividend's sign.
  - 10001 neg: lo = -B.
  - 10010 not: lo = ~B.
  - Any other code: result 0.
- Divide by zero: lo = 32'hFFFFFFFF, hi = A.
- Simultaneous load and drive of the same register: the register captures the old-value bus (normal edge semantics).
- Reset asserted mid-operation: immediate clear. The first load after release is on the next rising edge with clr = 1.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: op 01111 performs signed division as specified above.
- Undefined: op 01111 yields result 0 and no divider logic is synthesized.

Decomposition:
- Shared package holds:
  - op_sel constants: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL, OP_DIV, OP_MUL, OP_NEG, OP_NOT.
  - WIDTH.
  - Bus-source index constants for the encoder.
- One natural sub-module: datapath_alu (A, B, op_sel -> 64-bit result).
- Registers and the bus encoder stay in the top level.

Test Plan:
- Reset: clr = 0 with all enables high -> every view output reads 0. Release clr -> registers hold 0 until the next enabled edge.
- Register load: Mdatain = 32'h00FF5000, Read = 1, MDR_rd pulse -> MDR_view = 00FF5000. Then MDR_out = 1 with R_rd[2] = 1 -> r2_view = 00FF5000. Repeat with FFFF0054 into R6.
- mul: with R2 = 00FF5000 and R6 = FFFF0054, R_wrt[2] + Y_rd, then R_wrt[6] with op_sel = 10000 and Zhi_rd/Zlo_rd -> Zhi_view = FFFFFF01, Zlo_view = 03C64000. Zlo_out + LO_rd -> LO_view = 03C64000. Zhi_out + HI_rd -> HI_view = FFFFFF01.
- PC: MDR = 7, MDR_out + PC_rd -> PC_view = 7. IncPC pulse -> 8. PC_rd and IncPC together -> bus value wins.
- ALU sweep: Y = 32'h80000001, B = 4 -> ror = 18000000, shra = F8000000, shr = 08000000, sub = 7FFFFFFD. div -4/3 (with ALU_DIV_EN) -> lo = FFFFFFFF, hi = FFFFFFFF. Divide by 0 -> lo = FFFFFFFF, hi = A.
- Bus: no select asserted -> BusMuxOut = 0. R_wrt[3] and HI_out together -> R3 value on the bus. C_out with IR[18:0] = 7FFFF -> FFFFFFFF.
